// File: rtl/sa_psum_accumulator.sv
// Partial-sum accumulator behind the systolic array row drain: accumulates
// row_num SA rows over input-channel tiles, then drains finished rows downstream.
module sa_psum_accumulator #(
  parameter int unsigned row_num     = 4,
  parameter int unsigned column_num  = 4,
  parameter int unsigned pixel_width = 20,
  parameter int unsigned acc_width   = 32,
  parameter int unsigned ptr_width   = (row_num > 1) ? $clog2(row_num) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 in_valid,
  input  logic [pixel_width*2*column_num-1:0]  in_data,
  input  logic                                 first_tile,
  input  logic                                 last_tile,
  output logic                                 in_ready,
  output logic                                 out_valid,
  output logic [acc_width*2*column_num-1:0]    out_data,
  output logic [ptr_width-1:0]                 out_row,
  output logic                                 out_last,
  input  logic                                 out_ready,
  output logic                                 err_overflow,
  output logic                                 sat_flag
);

  localparam int unsigned lanes = 2 * column_num;
  localparam int unsigned row_w = lanes * acc_width;
  localparam logic [ptr_width-1:0] last_row = ptr_width'(row_num - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ptr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic                 pass_first_q, pass_first_d;
  logic                 pass_last_q, pass_last_d;
  logic                 err_q, err_d;
  logic                 sat_q, sat_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [ptr_width-1:0] out_row_q, out_row_d;
  logic                 out_last_q, out_last_d;
  logic [row_w-1:0]     out_data_q, out_data_d;

  logic [row_w-1:0]     row_buf_q [row_num];
  logic [row_w-1:0]     wr_row;
  logic                 beat;
  logic                 eff_first;
  logic                 eff_last;
  logic                 any_sat;
  logic                 drain_acc;

  assign beat      = in_valid & in_ready_q & ~clear;
  assign eff_first = (wr_ptr_q == '0) ? first_tile : pass_first_q;
  assign eff_last  = (wr_ptr_q == '0) ? last_tile : pass_last_q;
  assign drain_acc = out_valid_q & out_ready;

  // Per-lane sign extension and saturating add (or overwrite on a first-tile pass)
  always_comb begin
    logic signed [pixel_width-1:0] lane_s;
    logic signed [acc_width-1:0]   ext;
    logic signed [acc_width-1:0]   old;
    logic signed [acc_width:0]     sum;
    wr_row  = '0;
    any_sat = 1'b0;
    for (int k = 0; k < lanes; k++) begin
      lane_s = signed'(in_data[k*pixel_width +: pixel_width]);
      ext    = acc_width'(lane_s);
      old    = signed'(row_buf_q[wr_ptr_q][k*acc_width +: acc_width]);
      sum    = (acc_width+1)'(ext) + (acc_width+1)'(old);
      if (eff_first) begin
        wr_row[k*acc_width +: acc_width] = ext;
      end else if (sum[acc_width] != sum[acc_width-1]) begin
        any_sat = 1'b1;
        wr_row[k*acc_width +: acc_width] = sum[acc_width] ?
          {1'b1, {(acc_width-1){1'b0}}} : {1'b0, {(acc_width-1){1'b1}}};
      end else begin
        wr_row[k*acc_width +: acc_width] = sum[acc_width-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (beat && (wr_ptr_q == last_row) && eff_last) state_d = DRAIN;
      DRAIN:   if (drain_acc && out_last_q) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  // Pointers, pass flags, sticky flags and next values of the registered outputs
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pass_first_d = pass_first_q;
    pass_last_d  = pass_last_q;
    err_d        = err_q | (in_valid & ~in_ready_q);
    sat_d        = sat_q | (beat & any_sat);
    if (beat) begin
      wr_ptr_d = (wr_ptr_q == last_row) ? '0 : wr_ptr_q + 1'b1;
      if (wr_ptr_q == '0) begin
        pass_first_d = first_tile;
        pass_last_d  = last_tile;
      end
    end
    if (state_q == ACCUM && state_d == DRAIN) begin
      rd_ptr_d = '0;
    end else if (drain_acc) begin
      rd_ptr_d = (rd_ptr_q == last_row) ? '0 : rd_ptr_q + 1'b1;
    end
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      pass_first_d = 1'b0;
      pass_last_d  = 1'b0;
      err_d        = 1'b0;
      sat_d        = 1'b0;
    end
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DRAIN);
    out_row_d   = out_valid_d ? rd_ptr_d : '0;
    out_last_d  = out_valid_d && (rd_ptr_d == last_row);
    out_data_d  = '0;
    // Bypass covers row_num==1, where the final write and first read share row 0
    if (out_valid_d) begin
      out_data_d = (beat && (wr_ptr_q == rd_ptr_d)) ? wr_row : row_buf_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pass_first_q <= 1'b0;
      pass_last_q  <= 1'b0;
      err_q        <= 1'b0;
      sat_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pass_first_q <= pass_first_d;
      pass_last_q  <= pass_last_d;
      err_q        <= err_d;
      sat_q        <= sat_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
    end
  end

  // Accumulation buffer carries no reset; contents are only meaningful after a first-tile pass
  always_ff @(posedge clk) begin
    if (beat) row_buf_q[wr_ptr_q] <= wr_row;
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_row      = out_row_q;
  assign out_last     = out_last_q;
  assign err_overflow = err_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_sa_psum_accumulator.sv
// Scoreboard bench for sa_psum_accumulator: a 32-bit and a 21-bit accumulator
// instance share stimulus; expected rows come from a saturating bench model.
module tb_sa_psum_accumulator;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned LANES = 2 * COLS;
  localparam int unsigned PW    = 20;
  localparam int unsigned AW    = 32;
  localparam int unsigned AWS   = 21;

  typedef struct packed {
    logic [1:0]            row;
    logic                  last;
    logic [LANES*AW-1:0]   data;
  } row_t;

  logic clk = 1'b0;
  logic reset, clear, in_valid, first_tile, last_tile, out_ready;
  logic [LANES*PW-1:0] in_data;

  logic                 in_ready, out_valid, out_last, err_overflow, sat_flag;
  logic [1:0]           out_row;
  logic [LANES*AW-1:0]  out_data;
  logic                 s_in_ready, s_out_valid, s_out_last, s_err_overflow, s_sat_flag;
  logic [1:0]           s_out_row;
  logic [LANES*AWS-1:0] s_out_data;

  int vectors = 0;
  int miscompares = 0;

  row_t sb_m[$], sb_s[$], obs_m[$], obs_s[$];
  longint am [ROWS][LANES];
  longint as_ [ROWS][LANES];
  bit exp_sat_m, exp_sat_s;

  always #5 clk = ~clk;

  sa_psum_accumulator #(.row_num(ROWS), .column_num(COLS), .pixel_width(PW), .acc_width(AW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .first_tile(first_tile), .last_tile(last_tile), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .out_ready(out_ready), .err_overflow(err_overflow), .sat_flag(sat_flag));

  sa_psum_accumulator #(.row_num(ROWS), .column_num(COLS), .pixel_width(PW), .acc_width(AWS)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .first_tile(first_tile), .last_tile(last_tile), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_row(s_out_row), .out_last(s_out_last),
    .out_ready(out_ready), .err_overflow(s_err_overflow), .sat_flag(s_sat_flag));

  function automatic longint clampw(input longint x, input int unsigned w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -hi - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // One full pass; first/last are driven inverted on beats 1..3 since only beat 0 counts
  task automatic send_pass(input int base, input int rstep, input int kstep, input bit first, input bit last);
    for (int r = 0; r < int'(ROWS); r++) begin
      in_valid   = 1'b1;
      first_tile = (r == 0) ? first : ~first;
      last_tile  = (r == 0) ? last : ~last;
      for (int k = 0; k < int'(LANES); k++) in_data[k*PW +: PW] = PW'(base + r*rstep + k*kstep);
      @(posedge clk); #1;
      for (int k = 0; k < int'(LANES); k++) begin
        longint v = longint'(base + r*rstep + k*kstep);
        longint xm = first ? v : am[r][k] + v;
        longint xs = first ? v : as_[r][k] + v;
        am[r][k]  = clampw(xm, AW);
        as_[r][k] = clampw(xs, AWS);
        if (am[r][k] != xm) exp_sat_m = 1'b1;
        if (as_[r][k] != xs) exp_sat_s = 1'b1;
      end
    end
    in_valid = 1'b0; first_tile = 1'b0; last_tile = 1'b0;
    if (last) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        row_t em, es;
        em = '0; es = '0;
        em.row = 2'(r); es.row = 2'(r);
        em.last = (r == int'(ROWS) - 1); es.last = em.last;
        for (int k = 0; k < int'(LANES); k++) begin
          em.data[k*AW +: AW]  = AW'(am[r][k]);
          es.data[k*AWS +: AWS] = AWS'(as_[r][k]);
        end
        sb_m.push_back(em); sb_s.push_back(es);
      end
    end
  endtask

  // Collects accepted rows from both instances; stops at out_last or max_rows
  task automatic drain(input int max_rows, output bit to);
    int cyc = 0, n = 0;
    bit done = 1'b0;
    to = 1'b0;
    out_ready = 1'b1;
    while (!done) begin
      if (out_valid && out_ready) begin
        obs_m.push_back({out_row, out_last, out_data});
        n++;
        if (out_last || n >= max_rows) done = 1'b1;
      end
      if (s_out_valid && out_ready) obs_s.push_back({s_out_row, s_out_last, (LANES*AW)'(s_out_data)});
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc >= 50) begin to = 1'b1; done = 1'b1; end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; first_tile = 1'b0; last_tile = 1'b0;
    out_ready = 1'b0; in_data = '0;
    exp_sat_m = 1'b0; exp_sat_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, out_last, out_row, err_overflow, sat_flag} !== 7'b1000000 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_m: got rdy %b vld %b last %b row %0d err %b sat %b data %h, want 1 0 0 0 0 0 0",
               in_ready, out_valid, out_last, out_row, err_overflow, sat_flag, out_data);
    end
    vectors++;
    if ({s_in_ready, s_out_valid, s_out_last, s_out_row, s_err_overflow, s_sat_flag} !== 7'b1000000 || s_out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_s: got rdy %b vld %b row %0d data %h, want 1 0 0 0", s_in_ready, s_out_valid, s_out_row, s_out_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile;
    bit to;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL t1_idle_valid: got %b want 0", out_valid); end
    send_pass(1, 1, 0, 1'b1, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL t1_valid_rise: got vld %b rdy %b want 1 0", out_valid, in_ready);
    end
    drain(ROWS, to);
    vectors++;
    if (to || obs_m.size() != int'(ROWS) || obs_s.size() != int'(ROWS)) begin
      miscompares++; $display("FAIL t1_rows: got %0d/%0d rows timeout %b want %0d", obs_m.size(), obs_s.size(), to, ROWS);
    end
    while (obs_m.size() > 0 && sb_m.size() > 0) begin
      row_t o = obs_m.pop_front(), e = sb_m.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t1_row_m: got %h want %h", o, e); end
    end
    while (obs_s.size() > 0 && sb_s.size() > 0) begin
      row_t o = obs_s.pop_front(), e = sb_s.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t1_row_s: got %h want %h", o, e); end
    end
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL t1_return: got rdy %b vld %b want 1 0", in_ready, out_valid);
    end
    sb_m.delete(); sb_s.delete(); obs_m.delete(); obs_s.delete();
  endtask

  task automatic test_three_tile;
    bit to;
    send_pass(5, 0, 0, 1'b1, 1'b0);
    send_pass(-7, 0, 0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL t2_mid: got vld %b rdy %b want 0 1", out_valid, in_ready);
    end
    send_pass(100, 0, 0, 1'b0, 1'b1);
    drain(ROWS, to);
    vectors++;
    if (to || obs_m.size() != int'(ROWS)) begin
      miscompares++; $display("FAIL t2_rows: got %0d rows timeout %b want %0d", obs_m.size(), to, ROWS);
    end
    while (obs_m.size() > 0 && sb_m.size() > 0) begin
      row_t o = obs_m.pop_front(), e = sb_m.pop_front();
      vectors++;
      if (o !== e || o.data[31:0] !== 32'h0000_0062) begin miscompares++; $display("FAIL t2_row_m: got %h want %h", o, e); end
    end
    while (obs_s.size() > 0 && sb_s.size() > 0) begin
      row_t o = obs_s.pop_front(), e = sb_s.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL t2_row_s: got %h want %h", o, e); end
    end
    vectors++;
    if (sat_flag !== 1'b0 || s_sat_flag !== 1'b0) begin
      miscompares++; $display("FAIL t2_sat: got %b/%b want 0/0", sat_flag, s_sat_flag);
    end
    sb_m.delete(); sb_s.delete(); obs_m.delete(); obs_s.delete();
  endtask

  task automatic test_saturation;
    bit to;
    int vals [2] = '{524287, -524288};
    longint want [2] = '{1048575, -1048576};
    for (int p = 0; p < 2; p++) begin
      send_pass(vals[p], 0, 0, 1'b1, 1'b0);
      send_pass(vals[p], 0, 0, 1'b0, 1'b0);
      send_pass(vals[p], 0, 0, 1'b0, 1'b1);
      drain(ROWS, to);
      vectors++;
      if (to || obs_s.size() != int'(ROWS)) begin
        miscompares++; $display("FAIL t3_rows: got %0d rows timeout %b want %0d", obs_s.size(), to, ROWS);
      end
      while (obs_m.size() > 0 && sb_m.size() > 0) begin
        row_t o = obs_m.pop_front(), e = sb_m.pop_front();
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL t3_row_m: got %h want %h", o, e); end
      end
      while (obs_s.size() > 0 && sb_s.size() > 0) begin
        row_t o = obs_s.pop_front(), e = sb_s.pop_front();
        vectors++;
        if (o !== e || o.data[AWS-1:0] !== AWS'(want[p])) begin
          miscompares++; $display("FAIL t3_row_s: got %h want %h", o, e);
        end
      end
      vectors++;
      if (s_sat_flag !== 1'b1 || sat_flag !== exp_sat_m) begin
        miscompares++; $display("FAIL t3_sat: got s %b m %b want 1 %b", s_sat_flag, sat_flag, exp_sat_m);
      end
      sb_m.delete(); sb_s.delete(); obs_m.delete(); obs_s.delete();
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_sat_m = 1'b0; exp_sat_s = 1'b0;
    vectors++;
    if (s_sat_flag !== 1'b0) begin miscompares++; $display("FAIL t3_sat_clear: got %b want 0", s_sat_flag); end
  endtask

  task automatic test_back_to_back;
    bit to;
    send_pass(-300, 37, -11, 1'b1, 1'b0);
    send_pass(1000, -5, 13, 1'b0, 1'b1);
    drain(ROWS, to);
    send_pass(-4, 3, 7, 1'b1, 1'b1);
    drain(ROWS, to);
    vectors++;
    if (to || obs_m.size() != 2 * int'(ROWS)) begin
      miscompares++; $display("FAIL b2b_rows: got %0d rows timeout %b want %0d", obs_m.size(), to, 2 * ROWS);
    end
    while (obs_m.size() > 0 && sb_m.size() > 0) begin
      row_t o = obs_m.pop_front(), e = sb_m.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL b2b_row_m: got %h want %h", o, e); end
    end
    while (obs_s.size() > 0 && sb_s.size() > 0) begin
      row_t o = obs_s.pop_front(), e = sb_s.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL b2b_row_s: got %h want %h", o, e); end
    end
    sb_m.delete(); sb_s.delete(); obs_m.delete(); obs_s.delete();
  endtask

  task automatic test_backpressure;
    int accepts = 0, stall = 0, cyc = 0;
    send_pass(20, -9, 5, 1'b1, 1'b1);
    while (accepts < int'(ROWS) && cyc < 60) begin
      out_ready = !(out_valid && out_row == 2'd1 && stall < 5);
      if (!out_ready) begin
        stall++;
        vectors++;
        if (out_valid !== 1'b1 || out_row !== 2'd1 || out_data !== sb_m[0].data) begin
          miscompares++; $display("FAIL bp_stall: got vld %b row %0d data %h want 1 1 %h", out_valid, out_row, out_data, sb_m[0].data);
        end
      end
      if (out_valid && out_ready) begin
        row_t e = sb_m.pop_front();
        row_t es = sb_s.pop_front();
        vectors++;
        if ({out_row, out_last, out_data} !== e) begin
          miscompares++; $display("FAIL bp_row_m: got %h want %h", {out_row, out_last, out_data}, e);
        end
        vectors++;
        if ({s_out_row, s_out_last, (LANES*AW)'(s_out_data)} !== es) begin
          miscompares++; $display("FAIL bp_row_s: got %h want %h", {s_out_row, s_out_last, (LANES*AW)'(s_out_data)}, es);
        end
        accepts++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    vectors++;
    if (accepts != int'(ROWS) || stall != 5 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_count: got accepts %0d stalls %0d vld %b want %0d 5 0", accepts, stall, out_valid, ROWS);
    end
    sb_m.delete(); sb_s.delete();
  endtask

  task automatic test_overflow_clear;
    bit to;
    send_pass(-50, 17, 3, 1'b1, 1'b1);
    in_valid = 1'b1; first_tile = 1'b1; last_tile = 1'b1;
    for (int k = 0; k < int'(LANES); k++) in_data[k*PW +: PW] = PW'(777);
    @(posedge clk); #1;
    in_valid = 1'b0; first_tile = 1'b0; last_tile = 1'b0;
    vectors++;
    if (err_overflow !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL ovf_flag: got err %b rdy %b vld %b want 1 0 1", err_overflow, in_ready, out_valid);
    end
    drain(2, to);
    vectors++;
    if (to || obs_m.size() != 2) begin miscompares++; $display("FAIL ovf_rows: got %0d want 2", obs_m.size()); end
    while (obs_m.size() > 0 && sb_m.size() > 0) begin
      row_t o = obs_m.pop_front(), e = sb_m.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL ovf_row_m: got %h want %h", o, e); end
    end
    clear = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out_row, err_overflow} !== 5'b10000 || out_data !== '0) begin
      miscompares++; $display("FAIL clr_state: got rdy %b vld %b row %0d err %b data %h want 1 0 0 0 0",
                              in_ready, out_valid, out_row, err_overflow, out_data);
    end
    sb_m.delete(); sb_s.delete(); obs_m.delete(); obs_s.delete();
    send_pass(3, 2, -1, 1'b1, 1'b1);
    drain(ROWS, to);
    vectors++;
    if (to || obs_m.size() != int'(ROWS)) begin miscompares++; $display("FAIL clr_rows: got %0d want %0d", obs_m.size(), ROWS); end
    while (obs_m.size() > 0 && sb_m.size() > 0) begin
      row_t o = obs_m.pop_front(), e = sb_m.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL clr_row_m: got %h want %h", o, e); end
    end
    sb_m.delete(); sb_s.delete(); obs_m.delete(); obs_s.delete();
  endtask

  task automatic test_async_reset;
    bit to;
    in_valid = 1'b1; first_tile = 1'b1; last_tile = 1'b1;
    for (int k = 0; k < int'(LANES); k++) in_data[k*PW +: PW] = PW'(55);
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    vectors++;
    if ({in_ready, out_valid, out_last, out_row, err_overflow, sat_flag} !== 7'b1000000 || out_data !== '0) begin
      miscompares++; $display("FAIL arst_vals: got rdy %b vld %b last %b row %0d err %b sat %b want 1 0 0 0 0 0",
                              in_ready, out_valid, out_last, out_row, err_overflow, sat_flag);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    first_tile = 1'b0; last_tile = 1'b0;
    exp_sat_m = 1'b0; exp_sat_s = 1'b0;
    send_pass(9, 0, 0, 1'b1, 1'b1);
    drain(ROWS, to);
    vectors++;
    if (to || obs_m.size() != int'(ROWS)) begin miscompares++; $display("FAIL arst_rows: got %0d want %0d", obs_m.size(), ROWS); end
    while (obs_m.size() > 0 && sb_m.size() > 0) begin
      row_t o = obs_m.pop_front(), e = sb_m.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL arst_row_m: got %h want %h", o, e); end
    end
    while (obs_s.size() > 0 && sb_s.size() > 0) begin
      row_t o = obs_s.pop_front(), e = sb_s.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL arst_row_s: got %h want %h", o, e); end
    end
    sb_m.delete(); sb_s.delete(); obs_m.delete(); obs_s.delete();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_three_tile();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_overflow_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/sa_psum_accumulator.md
Name: sa_psum_accumulator

Overview:
- Downstream of the systolic array row-drain output.
- Captures one SA row result per beat (2*column_num lanes of pixel_width) across row_num beats per input-channel tile.
- Accumulates partial sums over successive tiles in a row_num-deep register buffer.
- After the last tile, drains the finished rows to the requantization/writeback stage over a valid/ready handshake.

Parameters:
- row_num, 4: SA rows; beats per tile pass and buffer depth.
- column_num, 4: SA columns; lanes per beat = 2*column_num.
- pixel_width, 20: signed width of each input lane.
- acc_width, 32: signed accumulator width per lane; must be >= pixel_width.
- ptr_width, $clog2(row_num): row pointer width (minimum 1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush. Returns to ACCUM with ptrs=0 and clears flags; buffer contents are not cleared.
- in_valid  input  1  beat present; driven from channel_out_en timing.
- in_data  input  pixel_width*2*column_num  one SA row, lane k at [k*pixel_width +: pixel_width], two's complement.
- first_tile  input  1  sampled on beat 0 of a pass; that pass overwrites instead of adding.
- last_tile  input  1  sampled on beat 0 of a pass; that pass triggers drain.
- in_ready  output  1  high in ACCUM.
- out_valid  output  1  drained row valid.
- out_data  output  acc_width*2*column_num  accumulated row, same lane order.
- out_row  output  ptr_width  row index of out_data.
- out_last  output  1  high with row row_num-1.
- out_ready  input  1  downstream accept.
- err_overflow  output  1  sticky; in_valid seen while in_ready=0.
- sat_flag  output  1  sticky; any lane saturated.

Behaviour:
- Reset (reset=0, async):
  - state=ACCUM, wr_ptr=0, rd_ptr=0.
  - in_ready=1, out_valid=0, out_last=0, out_row=0.
  - err_overflow=0, sat_flag=0, pass flags=0.
  - Buffer is not reset; out_data=0 because it is gated by out_valid.
- States: ACCUM, DRAIN.
- ACCUM, beat accepted (in_valid & in_ready):
  - If wr_ptr==0, latch pass_first=first_tile and pass_last=last_tile. The latched values apply to that beat and to the rest of the pass.
  - Per lane: ext = sign-extend(in lane) to acc_width.
  - If pass_first, buf[wr_ptr]=ext. Otherwise buf[wr_ptr]=sat(buf[wr_ptr]+ext), clamped to [-2^(acc_width-1), 2^(acc_width-1)-1].
  - Any clamp sets sat_flag.
  - Write takes effect at that edge (1-cycle latency).
  - wr_ptr increments and wraps row_num-1 -> 0.
- End of pass (beat at wr_ptr==row_num-1 accepted):
  - If pass_last, go to DRAIN at that edge: in_ready=0 from the next cycle, rd_ptr=0.
  - Otherwise stay in ACCUM for the next pass.
- DRAIN:
  - out_valid=1 continuously; out_data=buf[rd_ptr]; out_row=rd_ptr; out_last=(rd_ptr==row_num-1).
  - out_valid goes high the cycle after the final beat's edge.
  - out_data and out_row hold while out_ready=0.
  - On out_valid&out_ready, rd_ptr increments.
  - On acceptance with out_last: go to ACCUM, out_valid=0 next cycle, in_ready=1, wr_ptr=0.
- in_valid while in_ready=0: beat dropped, buffer unchanged, err_overflow set.
- clear has priority over all other events in the same cycle, including a beat or a handshake. A beat in the clear cycle is discarded without setting err_overflow.
- Async reset mid-pass or mid-drain: immediate return to reset values; the partial pass is lost.
- row_num==1: every accepted beat is a complete pass.
- A pass with first_tile=1 and last_tile=1 is a single-tile layer: overwrite, then drain.

Test Plan:
1. Single-tile layer:
   - Stimulus: row_num=4, column_num=4. Four beats with first=last=1; beat r has every lane = r+1.
   - Response: out_valid rises the cycle after beat 3. Rows 0..3 have all lanes = 1,2,3,4. out_last on row 3. in_ready returns to 1 after that accept.
2. Three-tile accumulation with signed data:
   - Stimulus: tile values 5, -7, 100 in all lanes and all rows; first on tile 1, last on tile 3.
   - Response: every lane = 98 (0x00000062); sat_flag=0.
3. Saturation (acc_width=21 override):
   - Stimulus: three tiles of lane value 524287.
   - Response: lanes = 1048575 and sat_flag=1. Repeat with -524288 x3: lanes = -1048576.
4. Backpressure in drain:
   - Stimulus: hold out_ready=0 for 5 cycles at row 1, then release.
   - Response: out_row=1 and out_data are stable through the stall. No row is skipped or duplicated; exactly 4 accepts occur.
5. Overflow and clear:
   - Stimulus: pulse in_valid during DRAIN.
   - Response: err_overflow=1 and buffer row values unchanged. Assert clear: state ACCUM, in_ready=1, out_valid=0, err_overflow=0 next cycle.
6. Async reset mid-pass:
   - Stimulus: drop reset after 2 of 4 beats. Release, then run a full single-tile pass with value 9.
   - Response: all outputs at reset values during reset; drained rows all = 9, with no residue from the aborted pass.
